// File: rtl/flap_mmio_pkg.sv
// Shared definitions for the flap button MMIO peripheral.
// Register offsets, bit positions and the event record.
package flap_mmio_pkg;

  localparam logic [3:0] OFF_STATUS = 4'h0;
  localparam logic [3:0] OFF_EVENT  = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  localparam int ST_NE      = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_LEVEL   = 8;
  localparam int ST_IRQ_EN  = 9;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_CLR_OVF = 2;

  typedef struct packed {
    logic        valid;
    logic [15:0] timestamp;
  } event_t;

  function automatic logic [31:0] event_word(
    input event_t e
  );
    return {e.valid, 15'b0, e.timestamp};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stability counter.
// Emits the debounced level and a one-cycle rise pulse.
module button_debounce #(
  parameter int CYCLES = 16
) (
  input  logic clock,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          done;

  assign done = (s2 != level) && (cnt == LAST);
  assign rise = done && s2;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (done) begin
        level <= s2;
        cnt   <= '0;
      end else if (s2 != level) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/flap_button_mmio.sv
// Flap button MMIO block: debounced presses become
// timestamped FIFO events popped by load or via irq.
module flap_button_mmio
  import flap_mmio_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_F000
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        btn_raw,
  input  logic        rd_en,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_hit,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic          level;
  logic          rise;
  logic [AW:0]   wp;
  logic [AW:0]   rp;
  logic [AW:0]   cnt;
  logic [15:0]   ts;
  logic [15:0]   mem [FIFO_DEPTH];
  logic          ovf;
  logic          irq_en;
  logic          rd_win;
  logic          ctrl_wr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          ovf_set;
  logic          flush;
  logic          clr_ovf;
  logic [3:0]    rd_off;
  event_t        head;
  logic [31:0]   status;
  logic [31:0]   rd_word;
  logic          unused_wr;

  button_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_deb (
    .clock (clock),
    .rst_n (rst_n),
    .din   (btn_raw),
    .level (level),
    .rise  (rise)
  );

  assign cnt   = wp - rp;
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);
  assign irq   = irq_en && !empty;

  assign rd_off  = rd_addr[3:0];
  assign rd_win  = rd_en &&
    (rd_addr[31:4] == BASE_ADDR[31:4]);
  assign ctrl_wr = wr_en &&
    (wr_addr[31:4] == BASE_ADDR[31:4]) &&
    (wr_addr[3:0] == OFF_CTRL);

  assign flush   = ctrl_wr && wr_data[CTRL_FLUSH];
  assign clr_ovf = ctrl_wr && wr_data[CTRL_CLR_OVF];
  assign pop     = rd_win && (rd_off == OFF_EVENT)
    && !empty;

  // A pop frees the slot a same-cycle push needs.
  assign push    = rise && !flush && (!full || pop);
  assign ovf_set = rise && !flush && full && !pop;

  assign head.valid     = 1'b1;
  assign head.timestamp = mem[rp[AW-1:0]];

  assign unused_wr = ^wr_data[31:3];

  always_comb begin
    status                    = '0;
    status[ST_NE]             = !empty;
    status[ST_OVF]            = ovf;
    status[ST_CNT_LSB +: 3]   = 3'(cnt);
    status[ST_LEVEL]          = level;
    status[ST_IRQ_EN]         = irq_en;
  end

  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      rd_off == OFF_STATUS: rd_word = status;
      pop:                  rd_word = event_word(head);
      default:              rd_word = '0;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wp      <= '0;
      rp      <= '0;
      ts      <= '0;
      ovf     <= 1'b0;
      irq_en  <= 1'b0;
      rd_data <= '0;
      rd_hit  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      ts      <= ts + 16'd1;
      rd_hit  <= rd_win;
      rd_data <= rd_win ? rd_word : '0;
      if (ctrl_wr) begin
        irq_en <= wr_data[CTRL_IRQ_EN];
      end
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
      if (flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        // Stamp with the value ts takes on this edge.
        if (push) begin
          mem[wp[AW-1:0]] <= ts + 16'd1;
          wp <= wp + 1'b1;
        end
        if (pop) begin
          rp <= rp + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_flap_button_mmio.sv
// Randomized bench for flap_button_mmio with a
// queue-based reference model and directed pins.
module tb_flap_button_mmio;

  localparam int          DEB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_F000;
  localparam logic [31:0] A_ST  = BASE;
  localparam logic [31:0] A_EV  = BASE + 32'd4;
  localparam logic [31:0] A_CT  = BASE + 32'd8;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_raw = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_hit;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        irq;

  int total = 0;
  int passed = 0;
  bit chk_on = 1'b0;

  flap_button_mmio #(
    .DEBOUNCE_CYCLES (DEB),
    .FIFO_DEPTH      (DEPTH),
    .BASE_ADDR       (BASE)
  ) dut (
    .clock   (clock),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_hit  (rd_hit),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .irq     (irq)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [15:0] m_ts;
  bit          m_sy1, m_sy2, m_lvl, m_ovf, m_ien, m_hit;
  int          m_run;
  logic [15:0] m_q[$];
  logic [31:0] m_rd;

  function automatic logic [31:0] m_status();
    int n;
    n = m_q.size();
    return (32'(m_ien) << 9) | (32'(m_lvl) << 8) |
           (32'(n) << 4) | (32'(m_ovf) << 1) |
           32'(n != 0);
  endfunction

  task automatic m_reset();
    m_ts = '0; m_sy1 = 0; m_sy2 = 0; m_lvl = 0;
    m_ovf = 0; m_ien = 0; m_hit = 0; m_run = 0;
    m_rd = '0; m_q.delete();
  endtask

  initial begin
    bit win, pop, fl, clr, rise;
    logic [31:0] off;
    m_reset();
    forever begin
      @(posedge clock or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else begin
        win = rd_en && rd_addr >= BASE && rd_addr < BASE + 32'd16;
        off = rd_addr - BASE;
        m_hit = win;
        m_rd = '0;
        pop = 0;
        if (win && off == 0) m_rd = m_status();
        if (win && off == 4 && m_q.size() > 0) begin
          m_rd = 32'h8000_0000 | 32'(m_q[0]);
          pop = 1;
        end
        fl = 0; clr = 0;
        if (wr_en && wr_addr == A_CT) begin
          m_ien = wr_data[0];
          fl = wr_data[1];
          clr = wr_data[2];
        end
        rise = 0;
        if (m_sy2 != m_lvl) begin
          m_run++;
          if (m_run == DEB) begin
            m_lvl = m_sy2;
            m_run = 0;
            rise = m_lvl;
          end
        end else begin
          m_run = 0;
        end
        m_sy2 = m_sy1;
        m_sy1 = btn_raw;
        if (pop) void'(m_q.pop_front());
        if (clr) m_ovf = 0;
        if (fl) m_q.delete();
        else if (rise) begin
          if (m_q.size() < DEPTH) m_q.push_back(m_ts + 16'd1);
          else m_ovf = 1;
        end
        m_ts = m_ts + 16'd1;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask

  initial forever begin
    @(negedge clock);
    if (rst_n && chk_on) begin
      chk("rd_hit", 32'(rd_hit), 32'(m_hit));
      chk("rd_data", rd_data, m_rd);
      chk("irq", 32'(irq), 32'(m_ien && m_q.size() > 0));
    end
  end

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(posedge clock); #1;
    rd_en = 1; rd_addr = a;
    @(posedge clock); #1;
    rd_en = 0;
    d = rd_data;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    wr_en = 1; wr_addr = a; wr_data = d;
    @(posedge clock); #1;
    wr_en = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(output logic [15:0] stamp);
    @(posedge clock); #1;
    stamp = m_ts + 16'd6;
    btn_raw = 1;
    idle(8);
    btn_raw = 0;
    idle(8);
  endtask

  task automatic wait_ts(input logic [15:0] t);
    int n;
    n = 0;
    while (m_ts != t && n < 70000) begin
      @(posedge clock); #1;
      n++;
    end
    if (m_ts != t) begin
      total++;
      $display("FAIL ts_wait: ts %h want %h", m_ts, t);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [15:0] st[5];
    logic [15:0] t0;
    logic [31:0] ra[8];
    logic [31:0] wa[4];
    int hold;

    ra = '{A_ST, A_EV, A_EV, A_CT, BASE + 32'hC,
           BASE + 32'd2, 32'h0000_1000, BASE + 32'd16};
    wa = '{A_CT, A_ST, BASE + 32'd9, 32'h0000_2008};

    idle(3);
    rst_n = 1;
    chk_on = 1;

    rd(A_ST, d);
    chk("reset_status", d, 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);

    wait_ts(16'd10);
    btn_raw = 1;
    idle(8);
    rd(A_ST, d);
    chk("press_status", d, 32'h111);
    rd(A_EV, d);
    chk("press_event", d, 32'h8000_0010);
    rd(A_ST, d);
    chk("after_pop_status", d, 32'h100);
    btn_raw = 0;
    idle(8);

    btn_raw = 1;
    idle(3);
    btn_raw = 0;
    idle(10);
    rd(A_ST, d);
    chk("glitch_status", d, 32'h0);

    for (int i = 0; i < 5; i++) press(st[i]);
    rd(A_ST, d);
    chk("ovf_status", d, 32'h43);
    for (int i = 0; i < 4; i++) begin
      rd(A_EV, d);
      chk("ovf_pop", d, 32'h8000_0000 | 32'(st[i]));
    end
    rd(A_EV, d);
    chk("empty_pop", d, 32'h0);
    rd(A_ST, d);
    chk("ovf_sticky", d, 32'h2);
    wr(A_CT, 32'h4);
    rd(A_ST, d);
    chk("ovf_cleared", d, 32'h0);

    wr(A_CT, 32'h1);
    press(st[0]);
    chk("irq_high", 32'(irq), 32'h1);
    rd(A_EV, d);
    chk("irq_event", d, 32'h8000_0000 | 32'(st[0]));
    chk("irq_low", 32'(irq), 32'h0);

    for (int i = 0; i < 4; i++) press(st[i]);
    @(posedge clock); #1;
    btn_raw = 1;
    repeat (5) @(posedge clock);
    #1;
    rd_en = 1; rd_addr = A_EV;
    @(posedge clock); #1;
    rd_en = 0;
    chk("full_pop_push", rd_data, 32'h8000_0000 | 32'(st[0]));
    rd(A_ST, d);
    chk("full_status", d, 32'h341);
    rd(A_EV, d);
    chk("full_next", d, 32'h8000_0000 | 32'(st[1]));
    wr(A_CT, 32'h3);
    rd(A_ST, d);
    chk("flush_status", d, 32'h300);
    btn_raw = 0;
    idle(8);

    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock); #1;
      if (hold == 0) begin
        btn_raw = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 12);
      end
      hold--;
      rd_en = ($urandom_range(0, 3) == 0);
      rd_addr = ra[$urandom_range(0, 7)];
      wr_en = ($urandom_range(0, 15) == 0);
      wr_addr = wa[$urandom_range(0, 3)];
      wr_data = $urandom;
      if (c == 1500) begin
        #2 rst_n = 0;
        #1;
        chk("async_rd_data", rd_data, 32'h0);
        chk("async_rd_hit", 32'(rd_hit), 32'h0);
        chk("async_irq", 32'(irq), 32'h0);
        idle(2);
        rst_n = 1;
      end
    end
    rd_en = 0; wr_en = 0; btn_raw = 0;
    idle(20);
    wr(A_CT, 32'h6);
    rd(A_ST, d);
    chk("pre_wrap_status", d, 32'h0);

    wait_ts(16'hFFFC);
    btn_raw = 1;
    idle(8);
    rd(A_EV, d);
    chk("wrap_event", d, 32'h8000_0002);
    btn_raw = 0;
    idle(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/flap_button_mmio.md
# flap_button_mmio

Memory-mapped input peripheral on the `uniprocessor` load/store bus, directly upstream of the core. It synchronizes and debounces the raw flap button. Each debounced press is captured as a timestamped event in a small FIFO. The game loop pops events by load, or takes an interrupt.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required to accept a level change (≥2).
- `FIFO_DEPTH`, 4: event slots; power of two.
- `BASE_ADDR`, 32'h0000_F000: word-aligned base of the 3-register window.
- `clock` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_raw` in 1: asynchronous button level, 1 = pressed.
- `rd_en` in 1: core load strobe.
- `rd_addr` in 32: load address.
- `rd_data` out 32: registered load data.
- `rd_hit` out 1: registered; previous-cycle load decoded to this window.
- `wr_en` in 1: core store strobe.
- `wr_addr` in 32: store address.
- `wr_data` in 32: store data.
- `irq` out 1: level interrupt, = `irq_en` & FIFO non-empty (registered state only).

## Operation
- Register map:
  - STATUS, BASE+0, read-only:
    - bit0: non-empty.
    - bit1: overflow (sticky).
    - [6:4]: count, 0..FIFO_DEPTH.
    - bit8: debounced level.
    - bit9: `irq_en`.
  - EVENT, BASE+4, read pops the FIFO: {bit31 valid, [15:0] timestamp}.
  - CTRL, BASE+8, write-only:
    - bit0: `irq_en` (stored).
    - bit1: flush (one-shot).
    - bit2: clear overflow (one-shot).
- Unmapped offsets: reads return 0 with `rd_hit`=1. Writes are ignored. Loads and stores outside the window have no effect, and give `rd_hit`=0.
- Input path: 2-flop synchronizer, then debouncer. The counter increments while sync ≠ stable and zeroes when sync = stable. When the counter reaches `DEBOUNCE_CYCLES`-1 with sync still ≠ stable, stable takes sync and the counter zeroes.
- Press event: stable 0→1. The event is pushed with the current 16-bit timestamp. Release events are not recorded.
- Timestamp: free-running 16-bit cycle counter, 0 after reset, wraps 0xFFFF→0x0000.
- FIFO boundaries:
  - Push when full: event dropped, overflow set.
  - Push and pop in the same cycle when full: both succeed, overflow unchanged.
  - Pop when empty: returns 0 (valid=0), no state change.
  - Flush in the same cycle as a push: flush wins, event discarded, overflow unchanged.
  - Flush and clear-overflow together: both apply.
- Write priority over read for CTRL side effects. A simultaneous STATUS read returns pre-write state.

## Timing
- Reset values (asynchronous on `rst_n`=0): `rd_data`=0, `rd_hit`=0, `irq`=0, `irq_en`=0, FIFO empty, overflow=0, stable=0, sync flops=0, timestamp=0, debounce counter=0.
- Load latency 1: `rd_data`/`rd_hit` are valid the cycle after `rd_en`. An EVENT pop updates the FIFO on the same edge that captures `rd_data`.
- Back-to-back EVENT reads on consecutive cycles pop consecutive entries.
- Press latency: `btn_raw` rise → stable rise = 2 + `DEBOUNCE_CYCLES` cycles if the input is held. The push lands on that same edge, so STATUS and `irq` reflect it the next cycle.
- Glitch shorter than `DEBOUNCE_CYCLES` cycles: no change, counter restarts.
- Reset mid-operation: everything returns to reset values. A press in progress is lost and is not replayed.

## Structure
- Package `flap_mmio_pkg`: register offsets, STATUS/CTRL bit positions, `event_t` packed struct {valid, timestamp}.
- Sub-module `button_debounce`: synchronizer plus counter, outputs stable level and rise pulse.
- Top level holds the FIFO, timestamp counter, decode and read mux.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4 and `FIFO_DEPTH`=4.
- Reset then read STATUS: `rd_data`=0, `irq`=0.
- Raise `btn_raw` at timestamp 10 and hold: event pushed at timestamp 16, STATUS=0x111 (count 1, level 1, non-empty). EVENT read returns 0x8000_0010 and STATUS then reads 0x100.
- Glitch `btn_raw` high for 3 cycles: no event, level stays 0.
- Five presses with no reads: count=4, overflow=1. Pops return the first four timestamps in order. CTRL write 0x4 clears overflow.
- Write CTRL=0x1, then one press: `irq` rises the cycle after the push. Pop the event: `irq` falls the cycle after the pop.
- FIFO full, pop on the same cycle as a new press: count stays 4, overflow stays 0. Timestamp crossing 0xFFFF→0 is recorded as 0x0000 plus offset.
